// File: rtl/mmio_io_responder_if.sv
// Processor data-memory port as seen by the MMIO responder.
// The master side is the processor and RAM. The slave side is the responder,
// which returns read data, gates the RAM write enable and flags window hits.
interface mmio_io_responder_if;
  logic [31:0] address_dmem;  // processor data word address
  logic        wren;          // processor write enable
  logic [31:0] data;          // processor write data
  logic [31:0] q_ram;         // RAM read data
  logic [31:0] q_dmem;        // read data returned to the processor
  logic        ram_wren;      // write enable forwarded to RAM
  logic        io_hit;        // address falls inside the I/O window

  modport master (
    output address_dmem, wren, data, q_ram,
    input  q_dmem, ram_wren, io_hit
  );

  modport slave (
    input  address_dmem, wren, data, q_ram,
    output q_dmem, ram_wren, io_hit
  );
endinterface

// File: rtl/mmio_io_responder.sv
// Memory-mapped I/O responder. It decodes a 4-word register window holding the
// debounced switches, the LED register, a sticky change flag and per-bit
// rising-edge latches. It steers read data between these registers and RAM,
// and blocks RAM writes that land inside the window.
module mmio_io_responder #(
  parameter int          SW_WIDTH        = 16,
  parameter int          LED_WIDTH       = 16,
  parameter logic [31:0] BASE_ADDR       = 32'd4096,
  parameter int          DEBOUNCE_CYCLES = 100000
) (
  input  logic                 clock,
  input  logic                 reset,   // asynchronous, active low
  mmio_io_responder_if.slave   bus,
  input  logic [SW_WIDTH-1:0]  SW,
  output logic [LED_WIDTH-1:0] LED
);

  localparam int             CNT_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    REG_SWITCH = 2'd0,
    REG_LED    = 2'd1,
    REG_STATUS = 2'd2,
    REG_EDGE   = 2'd3
  } reg_sel_e;

  logic [SW_WIDTH-1:0]  r_sync1, r_sync2, r_cand, r_stable, r_edge;
  logic [CNT_W-1:0]     r_cnt;
  logic [LED_WIDTH-1:0] r_led;
  logic                 r_chg;

  logic [31:0]          w_offset;
  logic                 w_hit;
  reg_sel_e             w_sel;
  logic                 w_wr_led, w_wr_status, w_wr_edge;
  logic                 w_settle;
  logic [SW_WIDTH-1:0]  w_rise;
  logic [SW_WIDTH-1:0]  w_edge_clr;
  logic                 w_unused_data;

  // Offset arithmetic keeps the decode correct even for a BASE_ADDR that is not 4-aligned.
  assign w_offset    = bus.address_dmem - BASE_ADDR;
  assign w_hit       = (w_offset < 32'd4);
  assign w_sel       = reg_sel_e'(w_offset[1:0]);
  assign w_wr_led    = bus.wren && w_hit && (w_sel == REG_LED);
  assign w_wr_status = bus.wren && w_hit && (w_sel == REG_STATUS);
  assign w_wr_edge   = bus.wren && w_hit && (w_sel == REG_EDGE);

  // RAM only decodes the low address bits, so it must never see window writes.
  assign bus.io_hit   = w_hit;
  assign bus.ram_wren = bus.wren & ~w_hit;
  assign LED          = r_led;

  // Only some write-data bits land in registers; the rest are intentionally ignored.
  assign w_unused_data = ^bus.data;

  // stable takes the candidate once it has held for DEBOUNCE_CYCLES consecutive samples.
  assign w_settle   = (r_sync2 == r_cand) && (r_cand != r_stable) && (r_cnt == CNT_MAX);
  assign w_rise     = w_settle ? (r_cand & ~r_stable) : '0;
  assign w_edge_clr = w_wr_edge ? bus.data[SW_WIDTH-1:0] : '0;

  // Read mux: window registers zero-extended, RAM data everywhere else.
  always_comb begin
    // NOTE: default first, so every path assigns q_dmem and no latch is inferred.
    bus.q_dmem = bus.q_ram;
    if (w_hit) begin
      unique case (w_sel)
        REG_SWITCH: bus.q_dmem = 32'(r_stable);
        REG_LED:    bus.q_dmem = 32'(r_led);
        REG_STATUS: bus.q_dmem = {31'd0, r_chg};
        REG_EDGE:   bus.q_dmem = 32'(r_edge);
      endcase
    end
  end

  // Two-flop synchroniser followed by a whole-vector debounce counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_cand   <= '0;
      r_stable <= '0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= SW;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_cand) begin
        r_cand <= r_sync2;
        r_cnt  <= '0;
      end else if (r_cand != r_stable) begin
        if (r_cnt == CNT_MAX) begin
          r_stable <= r_cand;
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  // LED output register, written through the window.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_led <= '0;
    end else if (w_wr_led) begin
      r_led <= bus.data[LED_WIDTH-1:0];
    end
  end

  // Sticky change flag and edge latches; a new event beats a same-cycle W1C clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_chg  <= 1'b0;
      r_edge <= '0;
    end else begin
      if (w_settle) begin
        r_chg <= 1'b1;
      end else if (w_wr_status && bus.data[0]) begin
        r_chg <= 1'b0;
      end
      r_edge <= (r_edge & ~w_edge_clr) | w_rise;
    end
  end

endmodule

// File: tb/tb_mmio_io_responder.sv
// Bench for mmio_io_responder. A behavioural model predicts every output on
// each cycle, and directed steps pin the key values with literals.
module tb_mmio_io_responder;
  localparam int          D    = 4;
  localparam logic [31:0] BASE = 32'd4096;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] sw;
  logic [15:0] led;

  always #5 clock = ~clock;

  mmio_io_responder_if bus();

  mmio_io_responder #(
    .SW_WIDTH(16), .LED_WIDTH(16), .BASE_ADDR(BASE), .DEBOUNCE_CYCLES(D)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus), .SW(sw), .LED(led)
  );

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Synced switch value = SW as seen two edges ago. stable takes a value once
  // the last D+1 synced samples all agree on it and it differs from stable.
  logic [15:0] m_led, m_stable, m_edge, m_d0, m_d1;
  logic        m_chg;
  logic [15:0] m_win[$];

  always @(posedge clock or negedge reset) begin : model
    logic [15:0] synced, nstable;
    logic [31:0] off;
    bit          same;
    if (!reset) begin
      m_led = '0; m_stable = '0; m_edge = '0; m_chg = 1'b0;
      m_d0 = '0; m_d1 = '0;
      m_win.delete();
    end else begin
      synced = m_d1;
      m_d1   = m_d0;
      m_d0   = sw;
      m_win.push_back(synced);
      if (m_win.size() > D + 1) void'(m_win.pop_front());
      nstable = m_stable;
      if (m_win.size() == D + 1) begin
        same = 1'b1;
        foreach (m_win[k]) if (m_win[k] != m_win[0]) same = 1'b0;
        if (same && m_win[0] != m_stable) nstable = m_win[0];
      end
      off = bus.address_dmem - BASE;
      if (bus.wren && off < 4) begin
        if (off == 1) m_led = bus.data[15:0];
        if (off == 2 && bus.data[0]) m_chg = 1'b0;
        if (off == 3) m_edge = m_edge & ~bus.data[15:0];
      end
      if (nstable != m_stable) m_chg = 1'b1;
      m_edge   = m_edge | (nstable & ~m_stable);
      m_stable = nstable;
    end
  end

  function automatic logic [31:0] m_read();
    logic [31:0] off;
    off = bus.address_dmem - BASE;
    if (off >= 4) return bus.q_ram;
    case (off)
      0:       return {16'd0, m_stable};
      1:       return {16'd0, m_led};
      2:       return {31'd0, m_chg};
      default: return {16'd0, m_edge};
    endcase
  endfunction

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clock) begin
    if (cmp_en) begin
      logic [31:0] off;
      off = bus.address_dmem - BASE;
      check("q_dmem_model", bus.q_dmem, m_read());
      check("io_hit_model", {31'd0, bus.io_hit}, {31'd0, off < 4});
      check("ram_wren_model", {31'd0, bus.ram_wren}, {31'd0, bus.wren && !(off < 4)});
      check("led_model", {16'd0, led}, {16'd0, m_led});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic rd(input logic [31:0] a);
    bus.address_dmem = a;
    bus.wren         = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.address_dmem = a;
    bus.wren         = 1'b1;
    bus.data         = d;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    sw = '0;
    bus.address_dmem = '0; bus.wren = 1'b0; bus.data = '0; bus.q_ram = 32'h5555_AAAA;
    step(); step();
    cmp_en = 1'b1;

    // 1: reset state reads
    rd(BASE);     #1 check("rst_switch", bus.q_dmem, 32'h0);
    rd(BASE + 1); #1 check("rst_led_reg", bus.q_dmem, 32'h0);
    rd(BASE + 2); #1 check("rst_status", bus.q_dmem, 32'h0);
    check("rst_led_pin", {16'd0, led}, 32'h0);
    step();
    reset = 1'b1;
    step();

    // 3: short glitch is rejected
    rd(BASE);
    sw = 16'h0001;
    step(); step(); step();
    sw = 16'h0000;
    for (int i = 0; i < 10; i++) begin
      step();
      #2 check("glitch_switch", bus.q_dmem, 32'h0);
    end
    rd(BASE + 2); #2 check("glitch_status", bus.q_dmem, 32'h0);
    step();

    // 2: held step is accepted on edge D+3
    rd(BASE);
    sw = 16'h00A5;
    for (int e = 1; e <= 8; e++) begin
      step();
      #2 check($sformatf("debounce_e%0d", e), bus.q_dmem, (e >= 7) ? 32'h0000_00A5 : 32'h0);
    end
    rd(BASE + 2); #2 check("status_set", bus.q_dmem, 32'h1);
    rd(BASE + 3); #2 check("edge_set", bus.q_dmem, 32'h0000_00A5);
    step();

    // 4: LED write, RAM write masking and pass-through
    wr(BASE + 1, 32'hDEAD_BEEF);
    #2 check("led_wr_ram_wren", {31'd0, bus.ram_wren}, 32'h0);
    check("led_wr_io_hit", {31'd0, bus.io_hit}, 32'h1);
    step();
    rd(BASE + 1);
    #2 check("led_pin", {16'd0, led}, 32'h0000_BEEF);
    check("led_read", bus.q_dmem, 32'h0000_BEEF);
    step();
    bus.q_ram = 32'h1234_5678;
    wr(32'd5, 32'h0);
    #2 check("ram_wren_out", {31'd0, bus.ram_wren}, 32'h1);
    check("ram_passthru", bus.q_dmem, 32'h1234_5678);
    check("ram_io_hit", {31'd0, bus.io_hit}, 32'h0);
    step();

    // 5: STATUS clear on the same edge stable changes: set wins
    rd(BASE);
    sw = 16'h00A7;
    for (int i = 0; i < 6; i++) step();
    wr(BASE + 2, 32'h1);
    step();
    rd(BASE + 2); #2 check("status_set_wins", bus.q_dmem, 32'h1);
    rd(BASE);     #0 check("switch_a7", bus.q_dmem, 32'h0000_00A7);
    step();
    wr(BASE + 2, 32'h1);
    step();
    rd(BASE + 2); #2 check("status_cleared", bus.q_dmem, 32'h0);
    step();

    // 6: EDGE W1C per bit
    wr(BASE + 3, 32'h2);
    step();
    rd(BASE + 3); #2 check("edge_clr_b1", bus.q_dmem, 32'h0000_00A5);
    step();
    wr(BASE + 3, 32'h4);
    step();
    rd(BASE + 3); #2 check("edge_clr_b2", bus.q_dmem, 32'h0000_00A1);
    step();

    // Reset in the middle of a debounce count
    rd(BASE);
    sw = 16'h0F00;
    step(); step(); step(); step();
    reset = 1'b0;
    #1 check("midrst_led", {16'd0, led}, 32'h0);
    rd(BASE);     #1 check("midrst_switch", bus.q_dmem, 32'h0);
    rd(BASE + 2); #1 check("midrst_status", bus.q_dmem, 32'h0);
    rd(BASE + 3); #1 check("midrst_edge", bus.q_dmem, 32'h0);
    step();
    reset = 1'b1;
    rd(BASE);
    for (int e = 1; e <= 8; e++) begin
      step();
      #2 check($sformatf("release_e%0d", e), bus.q_dmem, (e >= 7) ? 32'h0000_0F00 : 32'h0);
    end
    rd(BASE + 2); #2 check("release_status", bus.q_dmem, 32'h1);
    rd(BASE + 3); #2 check("release_edge", bus.q_dmem, 32'h0000_0F00);
    step(); step();

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
